// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the three sides of the unified-memory arbiter into one interface.
//   - fetch side : if_req/if_addr/if_flush in, if_gnt/if_rvalid/if_rdata out
//   - data side  : d_req/d_we/d_wmask/d_addr/d_wdata in,
//                  d_gnt/d_rvalid/d_rdata out
//   - memory side: mem_req/mem_we/mem_wmask/mem_addr/mem_wdata out,
//                  mem_ack/mem_rdata in
//   - status     : busy out
//   The arbiter connects through the master modport. The slave modport is
//   the view of the environment: requesters plus the memory.
interface mem_port_arbiter_if;
  // fetch stage
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  // memory stage
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_wmask;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  // unified memory
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  // status
  logic        busy;

  modport master (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_wmask, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_wmask, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output busy
  );

  modport slave (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_wmask, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_wmask, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch and the data
//   stage. Only one transaction is outstanding at a time. Data requests win
//   by default. After STARVE_MAX consecutive data grants while fetch is
//   waiting, fetch is forced to win. A flush drops the response of an
//   in-flight fetch, but the memory access itself still runs to completion.
// Ports
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset. All outputs read 0 while it is low.
//   bus : mem_port_arbiter_if.master, carrying the fetch, data and memory
//         handshakes plus busy
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_t      state_reg, state_next;
  logic [2:0]  starve_reg, starve_next;
  logic        drop_reg, drop_next;
  logic        we_reg, we_next;
  logic [3:0]  wmask_reg, wmask_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      starve_reg <= 3'd0;
      drop_reg   <= 1'b0;
      we_reg     <= 1'b0;
      wmask_reg  <= 4'd0;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
      drop_reg   <= drop_next;
      we_reg     <= we_next;
      wmask_reg  <= wmask_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    starve_next   = starve_reg;
    drop_next     = drop_reg;
    we_next       = we_reg;
    wmask_next    = wmask_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;

    bus.if_gnt    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = 32'd0;
    bus.d_gnt     = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = 32'd0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wmask = 4'd0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    bus.busy      = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        // Grants are combinational from the inputs, so they are explicitly
        // held off while reset is asserted. A mem_ack arriving here is a
        // leftover and is ignored.
        if (rst) begin
          if (bus.d_req && ((starve_reg < STARVE_LIM) || !bus.if_req)) begin
            bus.d_gnt  = 1'b1;
            we_next    = bus.d_we;
            wmask_next = bus.d_wmask;
            addr_next  = bus.d_addr;
            wdata_next = bus.d_wdata;
            state_next = BUSY_D;
            // Only data grants that overtake a waiting fetch count toward
            // starvation.
            if (bus.if_req)
              starve_next = (starve_reg < STARVE_LIM) ? starve_reg + 3'd1 : STARVE_LIM;
            else
              starve_next = 3'd0;
          end else if (bus.if_req && !bus.if_flush) begin
            bus.if_gnt  = 1'b1;
            we_next     = 1'b0;
            wmask_next  = 4'd0;
            addr_next   = bus.if_addr;
            wdata_next  = 32'd0;
            starve_next = 3'd0;
            state_next  = BUSY_I;
          end
        end
      end

      BUSY_I: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_reg;
        bus.mem_wmask = wmask_reg;
        bus.mem_addr  = addr_reg;
        bus.mem_wdata = wdata_reg;
        if (bus.if_flush)
          drop_next = 1'b1;
        if (bus.mem_ack) begin
          // A flush in the ack cycle itself must also drop the response.
          bus.if_rvalid = !(drop_reg || bus.if_flush);
          bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : 32'd0;
          drop_next     = 1'b0;
          state_next    = IDLE;
        end
      end

      BUSY_D: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_reg;
        bus.mem_wmask = wmask_reg;
        bus.mem_addr  = addr_reg;
        bus.mem_wdata = wdata_reg;
        if (bus.mem_ack) begin
          bus.d_rvalid = 1'b1;
          bus.d_rdata  = bus.mem_rdata;
          state_next   = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        drop_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scenarios followed by randomized requesters and a randomized
//   memory. A transaction-level predictor pushes the expected memory
//   transactions into a queue. A monitor compares the DUT against the
//   predictor every cycle and pops an entry when its response completes.
module tb_mem_port_arbiter;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        is_data;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } txn_t;

  txn_t txn_q[$];

  // Predictor state: who owns the memory (0 none, 1 fetch, 2 data), how many
  // data grants in a row have overtaken a waiting fetch, and whether the
  // current fetch response has been flushed.
  int          ref_owner  = 0;
  int          ref_starve = 0;
  bit          ref_drop   = 1'b0;
  logic        exp_rst, exp_busy, exp_ifg, exp_dg, exp_irv, exp_drv, exp_pop, exp_dropped;
  logic [31:0] exp_ird, exp_drd;

  // Predictor: samples the bench-driven inputs at the falling edge.
  always begin
    @(negedge clk);
    exp_ifg = 1'b0; exp_dg = 1'b0; exp_irv = 1'b0; exp_drv = 1'b0;
    exp_ird = 32'd0; exp_drd = 32'd0; exp_pop = 1'b0; exp_dropped = 1'b0;
    if (!rst) begin
      exp_rst    = 1'b1;
      exp_busy   = 1'b0;
      ref_owner  = 0;
      ref_starve = 0;
      ref_drop   = 1'b0;
      txn_q.delete();
    end else begin
      exp_rst  = 1'b0;
      exp_busy = (ref_owner != 0);
      if (ref_owner == 0) begin
        txn_t t;
        if (bus.d_req && (ref_starve < STARVE_MAX || !bus.if_req)) begin
          exp_dg    = 1'b1;
          t.is_data = 1'b1; t.addr = bus.d_addr; t.we = bus.d_we;
          t.wmask   = bus.d_wmask; t.wdata = bus.d_wdata;
          txn_q.push_back(t);
          if (bus.if_req) ref_starve = (ref_starve < STARVE_MAX) ? ref_starve + 1 : STARVE_MAX;
          else            ref_starve = 0;
          ref_owner = 2;
        end else if (bus.if_req && !bus.if_flush) begin
          exp_ifg   = 1'b1;
          t.is_data = 1'b0; t.addr = bus.if_addr; t.we = 1'b0;
          t.wmask   = 4'd0; t.wdata = 32'd0;
          txn_q.push_back(t);
          ref_starve = 0;
          ref_owner  = 1;
        end
      end else begin
        if (ref_owner == 1 && bus.if_flush) ref_drop = 1'b1;
        if (bus.mem_ack) begin
          if (ref_owner == 1) begin
            exp_irv     = !ref_drop;
            exp_ird     = ref_drop ? 32'd0 : bus.mem_rdata;
            exp_dropped = ref_drop;
          end else begin
            exp_drv = 1'b1;
            exp_drd = bus.mem_rdata;
          end
          exp_pop   = 1'b1;
          ref_owner = 0;
          ref_drop  = 1'b0;
        end
      end
    end
  end

  // Monitor: compares 1 ns after the predictor has run.
  always begin
    @(negedge clk);
    #1;
    chk1("if_gnt",    bus.if_gnt,    exp_ifg);
    chk1("d_gnt",     bus.d_gnt,     exp_dg);
    chk1("busy",      bus.busy,      exp_busy);
    chk1("mem_req",   bus.mem_req,   exp_busy);
    chk1("if_rvalid", bus.if_rvalid, exp_irv);
    chk1("d_rvalid",  bus.d_rvalid,  exp_drv);
    chk32("if_rdata", bus.if_rdata,  exp_ird);
    chk32("d_rdata",  bus.d_rdata,   exp_drd);
    if (exp_rst) begin
      chk1("rst_mem_we",     bus.mem_we,    1'b0);
      chk32("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
      chk32("rst_mem_addr",  bus.mem_addr,  32'd0);
      chk32("rst_mem_wdata", bus.mem_wdata, 32'd0);
    end
    if (exp_busy) begin
      chk32("txn_present", 32'(txn_q.size()), 32'd1);
      if (txn_q.size() > 0) begin
        chk1("mem_we",     bus.mem_we,    txn_q[0].we);
        chk32("mem_wmask", 32'(bus.mem_wmask), 32'(txn_q[0].wmask));
        chk32("mem_addr",  bus.mem_addr,  txn_q[0].addr);
        chk32("mem_wdata", bus.mem_wdata, txn_q[0].wdata);
      end
    end
    if (exp_pop && txn_q.size() > 0) begin
      $display("txn %s addr=%h we=%0d wmask=%h rdata=%h%s",
               txn_q[0].is_data ? "data " : "fetch", txn_q[0].addr, txn_q[0].we,
               txn_q[0].wmask, bus.mem_rdata, exp_dropped ? " dropped" : "");
      void'(txn_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random requester and memory state.
  bit f_pend = 1'b0, d_pend = 1'b0, f_got = 1'b0, d_got = 1'b0;
  int wait_cnt = 0;

  task automatic rand_cycle(input bit allow_new);
    if (f_got) f_pend = 1'b0;
    if (d_got) d_pend = 1'b0;
    if (allow_new && !f_pend && $urandom_range(0, 2) == 0) begin
      f_pend      = 1'b1;
      bus.if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (allow_new && !d_pend && $urandom_range(0, 1) == 0) begin
      d_pend      = 1'b1;
      bus.d_we    = 1'($urandom_range(0, 1));
      bus.d_wmask = 4'($urandom_range(0, 15));
      bus.d_addr  = $urandom;
      bus.d_wdata = $urandom;
    end
    bus.if_req   = f_pend;
    bus.d_req    = d_pend;
    bus.if_flush = allow_new && ($urandom_range(0, 9) == 0);
    if (bus.mem_req) begin
      if (wait_cnt == 0) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = $urandom;
      end else begin
        wait_cnt--;
        bus.mem_ack = 1'b0;
      end
    end else begin
      // Occasional spurious ack while idle; it must be ignored.
      wait_cnt      = $urandom_range(0, 3);
      bus.mem_ack   = allow_new && ($urandom_range(0, 15) == 0);
      bus.mem_rdata = $urandom;
    end
    #3;
    f_got = bus.if_gnt;
    d_got = bus.d_gnt;
    tick();
  endtask

  logic [9:0]  seq;
  logic [9:0]  exp_seq;
  int          gcount;
  int          rv_count;

  initial begin
    bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.if_flush = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wmask = 4'd0;
    bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;

    // Reset: requests present but no grant and nothing on the memory bus.
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    tick(); tick();
    #2;
    chk1("reset_if_gnt",  bus.if_gnt,  1'b0);
    chk1("reset_d_gnt",   bus.d_gnt,   1'b0);
    chk1("reset_mem_req", bus.mem_req, 1'b0);
    chk1("reset_busy",    bus.busy,    1'b0);
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Single fetch with zero-wait memory.
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    #2 chk1("fetch_gnt", bus.if_gnt, 1'b1);
    tick();
    bus.if_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0050_0093;
    #2;
    chk1("fetch_mem_req",   bus.mem_req,   1'b1);
    chk32("fetch_mem_addr", bus.mem_addr,  32'h100);
    chk1("fetch_rvalid",    bus.if_rvalid, 1'b1);
    chk32("fetch_rdata",    bus.if_rdata,  32'h0050_0093);
    tick();
    bus.mem_ack = 1'b0;
    #2 chk1("fetch_idle", bus.busy, 1'b0);
    tick();

    // Contention: the store goes first, then the fetch.
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2000;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_wmask = 4'hF;
    #2;
    chk1("cont_d_gnt",  bus.d_gnt,  1'b1);
    chk1("cont_if_gnt", bus.if_gnt, 1'b0);
    tick();
    bus.d_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
    #2;
    chk1("cont_mem_we",      bus.mem_we,    1'b1);
    chk32("cont_mem_wmask",  32'(bus.mem_wmask), 32'hF);
    chk32("cont_mem_addr",   bus.mem_addr,  32'h2000);
    chk32("cont_mem_wdata",  bus.mem_wdata, 32'hDEAD_BEEF);
    chk1("cont_d_rvalid",    bus.d_rvalid,  1'b1);
    tick();
    bus.mem_ack = 1'b0;
    #2 chk1("cont_if_gnt_next", bus.if_gnt, 1'b1);
    tick();
    bus.if_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0013;
    tick();
    bus.mem_ack = 1'b0;
    tick();

    // Starvation: both requests held high with zero-wait memory.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h3000; bus.d_wmask = 4'h0;
    bus.if_req = 1'b1; bus.if_addr = 32'h600;
    seq = 10'd0; gcount = 0;
    for (int c = 0; c < 40 && gcount < 10; c++) begin
      bus.mem_ack   = bus.mem_req;
      bus.mem_rdata = 32'(c);
      #2;
      if (bus.if_gnt || bus.d_gnt) begin
        seq[gcount] = bus.if_gnt;
        gcount++;
      end
      tick();
    end
    exp_seq = 10'b10_0001_0000;
    chk32("starve_count", 32'(gcount), 32'd10);
    chk32("starve_seq",   32'(seq),    32'(exp_seq));
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    for (int c = 0; c < 10 && bus.busy; c++) begin
      bus.mem_ack = bus.mem_req;
      tick();
    end
    bus.mem_ack = 1'b0;
    chk1("starve_drained", bus.busy, 1'b0);
    tick();

    // Flush in the middle of a fetch; ack three cycles after the flush.
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    #2 chk1("flush_gnt", bus.if_gnt, 1'b1);
    tick();
    bus.if_req = 1'b0; bus.if_flush = 1'b1;
    #2 chk1("flush_mem_req_1", bus.mem_req, 1'b1);
    tick();
    bus.if_flush = 1'b0;
    #2 chk1("flush_mem_req_2", bus.mem_req, 1'b1);
    tick();
    #2 chk1("flush_mem_req_3", bus.mem_req, 1'b1);
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    #2;
    chk1("flush_mem_req_ack", bus.mem_req,   1'b1);
    chk1("flush_no_rvalid",   bus.if_rvalid, 1'b0);
    tick();
    bus.mem_ack = 1'b0;
    #2 chk1("flush_idle", bus.busy, 1'b0);
    tick();

    // Reset in the middle of a load.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h400;
    #2 chk1("rstmid_gnt", bus.d_gnt, 1'b1);
    tick();
    bus.d_req = 1'b0;
    #1 chk1("rstmid_mem_req_before", bus.mem_req, 1'b1);
    rst = 1'b0;
    #1;
    chk1("rstmid_mem_req", bus.mem_req, 1'b0);
    chk1("rstmid_busy",    bus.busy,    1'b0);
    tick();
    rst = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
    #2;
    chk1("late_ack_d_rvalid",  bus.d_rvalid,  1'b0);
    chk1("late_ack_if_rvalid", bus.if_rvalid, 1'b0);
    tick();
    bus.mem_ack = 1'b0;
    tick();

    // Load against a memory with five wait cycles.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500; bus.d_wmask = 4'h0;
    #2 chk1("wait_gnt", bus.d_gnt, 1'b1);
    tick();
    bus.d_req = 1'b0;
    rv_count = 0;
    for (int c = 1; c <= 7; c++) begin
      bus.mem_ack   = (c == 6);
      bus.mem_rdata = 32'h0BAD_F00D;
      #2;
      if (c <= 5) begin
        chk1("wait_mem_req",   bus.mem_req,  1'b1);
        chk32("wait_mem_addr", bus.mem_addr, 32'h500);
      end
      if (bus.d_rvalid) rv_count++;
      tick();
    end
    bus.mem_ack = 1'b0;
    chk32("wait_rvalid_count", 32'(rv_count), 32'd1);

    // Randomized traffic, then let pending requests finish.
    for (int c = 0; c < 1500; c++) rand_cycle(1'b1);
    for (int c = 0; c < 60 && (f_pend || d_pend || bus.busy); c++) rand_cycle(1'b0);
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.mem_ack = 1'b0; bus.if_flush = 1'b0;
    chk1("drain_requests_done", f_pend || d_pend, 1'b0);
    chk1("drain_idle", bus.busy, 1'b0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
